// File: rtl/pipe_stage.sv
// pipe_stage: single-entry-plus-skid pipeline register with valid/ready
// handshaking on both sides. The main register drives out_data and the skid
// register catches the beat accepted while the downstream stalls. This lets
// in_ready come straight from a flop without losing throughput.
//
// Optional feature: define PIPE_STAGE_FLUSH_EN to make the flush input
// discard every held beat. Without the macro, flush is ignored and no flush
// logic is built.
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occ
);

  // Occupancy states: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             in_ready_r;
  logic             in_ready_s;
  logic             out_valid_r;
  logic             out_valid_s;
  logic [1:0]       occ_r;
  logic [1:0]       occ_s;

  logic             in_fire_s;
  logic             out_fire_s;

`ifndef PIPE_STAGE_FLUSH_EN
  // The flush pin stays on the port list so both builds share one footprint.
  logic             unused_flush;
  assign unused_flush = flush;
`endif

  // Handshakes use the registered flags, which mirror the current state.
  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state, storage update and next registered outputs.
  always_comb begin
    state_s     = state_r;
    main_s      = main_r;
    skid_s      = skid_r;
    in_ready_s  = 1'b1;
    out_valid_s = 1'b0;
    occ_s       = 2'd0;

    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_s = ST_ONE;
          main_s  = in_data;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire_s && out_fire_s) begin
          state_s = ST_ONE;
          main_s  = in_data;
        end else if (out_fire_s) begin
          // Main keeps the delivered value so out_data holds it while empty.
          state_s = ST_EMPTY;
        end else if (in_fire_s) begin
          state_s = ST_TWO;
          skid_s  = in_data;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (out_fire_s) begin
          state_s = ST_ONE;
          main_s  = skid_r;
        end else begin
          state_s = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
        main_s  = RESET_VAL;
        skid_s  = RESET_VAL;
      end
    endcase

`ifdef PIPE_STAGE_FLUSH_EN
    // Flush drops held beats and any beat taken in the same cycle.
    if (flush) begin
      state_s = ST_EMPTY;
      main_s  = RESET_VAL;
      skid_s  = RESET_VAL;
    end else begin
      state_s = state_s;
    end
`endif

    case (state_s)
      ST_EMPTY: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        occ_s       = 2'd0;
      end
      ST_ONE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b1;
        occ_s       = 2'd1;
      end
      ST_TWO: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
        occ_s       = 2'd2;
      end
      default: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        occ_s       = 2'd0;
      end
    endcase
  end

  // State, storage and output flags; clr wins over every transfer and flush.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_VAL;
      skid_r      <= RESET_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      occ_r       <= occ_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occ       = occ_r;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: three widths (8/32/64) share one stimulus stream and
// one queue-based reference model. A table of directed vectors with
// hand-computed expectations covers reset, fill, stall and drain. Short
// hand-written sequences cover flush, throughput and random traffic.
module tb_pipe_stage;

  localparam logic [7:0]  RV8  = 8'h5A;
  localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
  localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;
`ifdef PIPE_STAGE_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready8,  out_valid8;
  logic        in_ready32, out_valid32;
  logic        in_ready64, out_valid64;
  logic [7:0]  out_data8;
  logic [31:0] out_data32;
  logic [63:0] out_data64;
  logic [1:0]  occ8, occ32, occ64;

  pipe_stage #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data[7:0]), .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .flush(flush), .occ(occ8)
  );

  pipe_stage #(.WIDTH(32), .RESET_VAL(RV32)) dut32 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready32),
    .in_data(in_data[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_data(out_data32), .flush(flush), .occ(occ32)
  );

  pipe_stage #(.WIDTH(64), .RESET_VAL(RV64)) dut64 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready64),
    .in_data(in_data), .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .flush(flush), .occ(occ64)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  int          n_out = 0;
  int          n_dut_fire = 0;
  bit          seen7 = 1'b0;
  logic [63:0] mq[$];
  logic [63:0] last_val = 64'd0;
  bit          last_rst = 1'b1;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [1:0]  eo;
    logic [31:0] ed;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_val(input logic [63:0] rv);
    if (mq.size() > 0) return mq[0];
    else if (last_rst) return rv;
    else return last_val;
  endfunction

  task automatic check_state();
    logic [1:0] eo;
    logic       ev;
    logic       er;
    eo = 2'(mq.size());
    ev = (mq.size() > 0);
    er = (mq.size() < 2);
    chk("d8_valid",  {63'd0, out_valid8},  {63'd0, ev});
    chk("d8_ready",  {63'd0, in_ready8},   {63'd0, er});
    chk("d8_occ",    {62'd0, occ8},        {62'd0, eo});
    chk("d8_data",   {56'd0, out_data8},   exp_val({56'd0, RV8}) & 64'h0000_0000_0000_00FF);
    chk("d32_valid", {63'd0, out_valid32}, {63'd0, ev});
    chk("d32_ready", {63'd0, in_ready32},  {63'd0, er});
    chk("d32_occ",   {62'd0, occ32},       {62'd0, eo});
    chk("d32_data",  {32'd0, out_data32},  exp_val({32'd0, RV32}) & 64'h0000_0000_FFFF_FFFF);
    chk("d64_valid", {63'd0, out_valid64}, {63'd0, ev});
    chk("d64_ready", {63'd0, in_ready64},  {63'd0, er});
    chk("d64_occ",   {62'd0, occ64},       {62'd0, eo});
    chk("d64_data",  out_data64,           exp_val(RV64));
  endtask

  // One clock: drive at negedge, score the pre-edge handshake, update the
  // model at the edge, check outputs at the next negedge.
  task automatic cycle(input logic rst, input logic iv, input logic [63:0] id,
                       input logic ordy, input logic fl);
    bit          out_f;
    bit          in_f;
    logic [63:0] popped;
    clr       = rst;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    out_f = (mq.size() > 0) && ordy;
    in_f  = iv && (mq.size() < 2);
    if (out_valid32 === 1'b1 && ordy) begin
      n_dut_fire++;
      if (out_data32 == 32'h7) seen7 = 1'b1;
    end
    if (out_f && !rst) begin
      popped = mq[0];
      chk("sb_d8",  {56'd0, out_data8},  popped & 64'h0000_0000_0000_00FF);
      chk("sb_d32", {32'd0, out_data32}, popped & 64'h0000_0000_FFFF_FFFF);
      chk("sb_d64", out_data64,          popped);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      last_rst = 1'b1;
    end else if (FLUSH_EN && fl) begin
      if (out_f) n_out++;
      mq.delete();
      last_rst = 1'b1;
    end else begin
      if (out_f) begin
        last_val = mq.pop_front();
        last_rst = 1'b0;
        n_out++;
      end
      if (in_f) mq.push_back(id);
    end
    @(negedge clk);
    check_state();
  endtask

  int base_out;
  int base_fire;

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0; flush = 1'b0;

    //        rst   iv    id             ordy  ev    er    eo     ed
    tbl[0]  = '{1'b1, 1'b1, 32'h0000_0099, 1'b1, 1'b0, 1'b1, 2'd0, RV32};
    tbl[1]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA5A5_0001};
    tbl[2]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'd0, 32'hA5A5_0001};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0011};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0011};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0011};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0033, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0022};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0033, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0033};
    tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0033};
    tbl[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0033};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0044};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0044};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0066, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0044};
    tbl[13] = '{1'b0, 1'b0, 32'h0000_0077, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0044};
    tbl[14] = '{1'b1, 1'b1, 32'h0000_0099, 1'b1, 1'b0, 1'b1, 2'd0, RV32};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_0088, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0088};
    tbl[16] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0088};

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].rst, tbl[i].iv, {32'd0, tbl[i].id}, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid32}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_ready", i), {63'd0, in_ready32},  {63'd0, tbl[i].er});
      chk($sformatf("tbl%0d_occ", i),   {62'd0, occ32},       {62'd0, tbl[i].eo});
      chk($sformatf("tbl%0d_data", i),  {32'd0, out_data32},  {32'd0, tbl[i].ed});
    end

    // Flush while two beats are held and a third is offered.
    cycle(1'b0, 1'b1, 64'h5, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'h6, 1'b0, 1'b0);
    base_out = n_out;
    seen7 = 1'b0;
    cycle(1'b0, 1'b1, 64'h7, 1'b0, 1'b1);
`ifdef PIPE_STAGE_FLUSH_EN
    chk("flush_occ",   {62'd0, occ32},       64'd0);
    chk("flush_valid", {63'd0, out_valid32}, 64'd0);
    chk("flush_data",  {32'd0, out_data32},  {32'd0, RV32});
`else
    chk("noflush_occ",   {62'd0, occ32},       64'd2);
    chk("noflush_valid", {63'd0, out_valid32}, 64'd1);
    chk("noflush_data",  {32'd0, out_data32},  64'h5);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("flush_seen7", {63'd0, seen7}, 64'd0);
    chk("flush_outs", 64'(n_out - base_out), FLUSH_EN ? 64'd0 : 64'd2);

    // Back-to-back stream of 100 beats with the sink always ready.
    base_out = n_out;
    base_fire = n_dut_fire;
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 64'(i), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("thru_model_outs", 64'(n_out - base_out), 64'd100);
    chk("thru_dut_fires", 64'(n_dut_fire - base_fire), 64'd100);

    // Random traffic with occasional flush and clr.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 499) == 0),
            1'($urandom_range(0, 1)),
            {$urandom, $urandom},
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
    end

    // Reset with two beats held.
    cycle(1'b0, 1'b1, 64'hAB, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'hCD, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("rst2_occ",   {62'd0, occ32},       64'd0);
    chk("rst2_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst2_ready", {63'd0, in_ready32},  64'd1);
    chk("rst2_data",  {32'd0, out_data32},  {32'd0, RV32});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal 1..64).
REQ-002 SHALL have parameter RESET_VAL, default all-zero, value driven on out_data after reset and flush.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream beat present.
REQ-006 SHALL have port in_ready  output  1  stage can accept a beat; driven from a flop only.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload; driven from a flop only.
REQ-011 SHALL have port flush  input  1  discard all held beats (active only with the Configuration macro).
REQ-012 SHALL have port occ  output  2  beats currently held (0, 1 or 2).

Function
- REQ-013 Input transfer SHALL occur when in_valid and in_ready are high on a clock edge; output transfer SHALL occur when out_valid and out_ready are high.
- REQ-014 Storage SHALL consist of a main register (drives out_data) and one skid register.
- REQ-015 States SHALL be EMPTY (occ=0), ONE (main valid), TWO (main and skid valid); out_valid=1 in ONE and TWO; in_ready=1 in EMPTY and ONE, 0 in TWO.
- REQ-016 EMPTY: input transfer -> ONE, main<=in_data; otherwise stay.
- REQ-017 ONE: input and output transfer -> ONE, main<=in_data; output only -> EMPTY; input only -> TWO, skid<=in_data; neither -> stay.
- REQ-018 TWO: output transfer -> ONE, main<=skid; otherwise stay; no input transfer possible.
- REQ-019 Latency in_data to out_data SHALL be 1 cycle from EMPTY; sustained throughput SHALL be 1 beat/cycle while out_ready=1.
- REQ-020 Beats SHALL leave in acceptance order; none duplicated or lost except by flush.
- REQ-021 out_data SHALL hold its value while out_valid=1 and out_ready=0; in EMPTY it SHALL hold the last value (RESET_VAL after reset/flush).
- REQ-022 in_valid or in_data changing while in_ready=0 SHALL have no effect.

Reset
- REQ-023 clr=1 on a clock edge SHALL force EMPTY: out_valid=0, in_ready=1, occ=0, out_data=RESET_VAL, skid cleared to RESET_VAL.
- REQ-024 clr SHALL override every concurrent transfer and flush; beats handshaken in the reset cycle SHALL be discarded.
- REQ-025 Reset asserted mid-stream SHALL leave no residual beat; the first post-reset accepted beat SHALL be the first output.

Configuration
- REQ-026 Macro PIPE_STAGE_FLUSH_EN defined: flush=1 on an edge SHALL force EMPTY, out_data=RESET_VAL, in_ready=1 next cycle, discarding held beats and any beat input-transferred in that same cycle; an output transfer in that cycle SHALL still count as delivered.
- REQ-027 PIPE_STAGE_FLUSH_EN undefined: flush SHALL be ignored, no flush logic synthesised; all other behaviour identical.
- REQ-028 clr SHALL take priority over flush when both high.

Verification
- REQ-029 Reset then in_valid=1, in_data=0xA5A5_0001, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5_0001, occ=1.
- REQ-030 out_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> 0x11 and 0x22 accepted, in_ready=0 at third cycle, occ=2; then out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, no gaps.
- REQ-031 Continuous in_valid=1 incrementing data 0..99, out_ready=1 -> 100 outputs on 100 consecutive cycles, in order.
- REQ-032 Random in_valid/out_ready 10k cycles, WIDTH=8 and WIDTH=64 -> scoreboard exact in-order match, occ never >2, in_ready==(occ<2).
- REQ-033 With PIPE_STAGE_FLUSH_EN, occ=2 holding 0x5,0x6, flush=1 with in_valid=1 data 0x7 -> next cycle occ=0, out_valid=0, out_data=RESET_VAL; 0x7 never output. Without macro, same stimulus -> 0x5 stays on out_data, occ=2, no beat lost.
- REQ-034 clr=1 while occ=2 and flush=0 -> next cycle occ=0, out_valid=0, in_ready=1, out_data=RESET_VAL.
